// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one register stage per shift level, valid/ready with global stall.
// Optional rotate-right on op 11 when SHIFTER_ROTATE_EN is defined (otherwise op 11 acts as SRL).
module pipelined_barrel_shifter #(
  parameter  int N = 32,
  localparam int L = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in,
  input  logic [L-1:0] shamt,
  input  logic [1:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // The whole pipe freezes when the last stage holds a result the consumer refuses.
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int SH = 1 << k;

    logic [N-1:0]   d_in;
    logic           v_in;
    logic [L-1-k:0] rem_in;
    logic [1:0]     op_in;
    logic [N-1:0]   d_next;
    logic [N-1:0]   data_q;
    logic           valid_q;

    if (k == 0) begin : g_first
      assign d_in   = in;
      assign v_in   = in_valid;
      assign rem_in = shamt;
      assign op_in  = op;
    end else begin : g_next
      assign d_in   = g_stage[k-1].data_q;
      assign v_in   = g_stage[k-1].valid_q;
      assign rem_in = g_stage[k-1].g_side.rem_q;
      assign op_in  = g_stage[k-1].g_side.op_q;
    end

    // SRA never changes the MSB, so the original sign bit rides down the pipe in data[N-1].
    always_comb begin
      d_next = d_in;
      if (rem_in[0]) begin
        case (op_in)
          2'b00:   d_next = {d_in[N-1-SH:0], {SH{1'b0}}};
          2'b10:   d_next = {{SH{d_in[N-1]}}, d_in[N-1:SH]};
`ifdef SHIFTER_ROTATE_EN
          2'b11:   d_next = {d_in[SH-1:0], d_in[N-1:SH]};
`endif
          default: d_next = {{SH{1'b0}}, d_in[N-1:SH]};
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (!stall) begin
        valid_q <= v_in;
        data_q  <= d_next;
      end
    end

    // Only stages with work left downstream carry the remaining shift bits and opcode.
    if (k < L - 1) begin : g_side
      logic [L-2-k:0] rem_q;
      logic [1:0]     op_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rem_q <= '0;
          op_q  <= 2'b00;
        end else if (!stall) begin
          rem_q <= rem_in[L-1-k:1];
          op_q  <= op_in;
        end
      end
    end
  end

  assign out       = g_stage[L-1].data_q;
  assign out_valid = g_stage[L-1].valid_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: directed cases, backpressure, mid-stream reset,
// then randomized traffic against an arithmetic reference model.
module tb_pipelined_barrel_shifter;
  localparam int N = 32;
  localparam int L = $clog2(N);

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_d;
  logic [L-1:0] shamt;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_d;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in_d),
    .shamt(shamt), .op(op), .out_valid(out_valid), .out_ready(out_ready), .out(out_d)
  );

  logic [N-1:0] exp_q[$];
  int           acc_q[$];
  int           stl_q[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           stall_cnt = 0;
  int           hold_seen = 0;
  bit           rst_at_edge = 1'b0;
  bit           rand_bp = 1'b0;
  bit           prev_stall = 1'b0;
  logic [N-1:0] prev_out = '0;

  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] x, input int s, input logic [1:0] o);
    logic [N-1:0] r;
    case (o)
      2'b00:   r = x << s;
      2'b01:   r = x >> s;
      2'b10:   r = $signed(x) >>> s;
`ifdef SHIFTER_ROTATE_EN
      default: r = (s == 0) ? x : ((x >> s) | (x << (N - s)));
`else
      default: r = x >> s;
`endif
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Clock/reset bookkeeping
  always @(posedge clk) begin
    cyc++;
    rst_at_edge = rst;
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_at_edge) begin
      check("reset_out_valid", {{(N-1){1'b0}}, out_valid}, '0);
      check("reset_out", out_d, '0);
      check("reset_in_ready", {{(N-1){1'b0}}, in_ready}, {{(N-1){1'b0}}, 1'b1});
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_out", out_d, prev_out);
        check("stall_hold_valid", {{(N-1){1'b0}}, out_valid}, {{(N-1){1'b0}}, 1'b1});
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", {{(N-1){1'b0}}, in_ready}, '0);
        stall_cnt++;
        prev_stall = 1'b1;
        prev_out = out_d;
      end else begin
        check("in_ready", {{(N-1){1'b0}}, in_ready}, {{(N-1){1'b0}}, 1'b1});
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %h expected no output (cycle %0d)", out_d, cyc);
        end else begin
          int a, s;
          check("result", out_d, exp_q.pop_front());
          a = acc_q.pop_front();
          s = stl_q.pop_front();
          check_int("latency", cyc - a, L + stall_cnt - s);
        end
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic send(input logic [N-1:0] d, input int s, input logic [1:0] o);
    int budget = 0;
    in_valid = 1'b1;
    in_d = d;
    shamt = L'(s);
    op = o;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ref_shift(d, s, o));
        acc_q.push_back(cyc);
        stl_q.push_back(stall_cnt);
        break;
      end
      budget++;
      if (budget > 1000) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", budget);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_d = $urandom;
    shamt = L'($urandom);
    op = 2'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    acc_q.delete();
    stl_q.delete();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_d = '0;
    shamt = '0;
    op = 2'b00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single op latency and maximum left shift
    send(32'h0000_0001, 31, 2'b00);
    idle(8);

    // SRA then SRL on consecutive cycles
    send(32'h8000_00F0, 4, 2'b10);
    send(32'h8000_00F0, 4, 2'b01);
    idle(8);

    // Streaming with a 3-cycle hold once the first result appears
    fork
      for (int i = 0; i < 8; i++) send(32'hA5A5_A5A5, i, 2'b00);
      begin
        int t = 0;
        while (!out_valid && t < 100) begin
          @(posedge clk);
          #1;
          t++;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!in_ready && out_valid) hold_seen++;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    check_int("hold_cycles", hold_seen, 3);
    idle(12);

    // Rotate (or SRL when rotate is not built)
    send(32'h0000_00FF, 4, 2'b11);
    idle(8);

    // Boundary shifts
    send(32'h8000_0000, 31, 2'b10);
    send(32'h8000_0000, 31, 2'b01);
    send(32'h7FFF_FFFF, 31, 2'b10);
    idle(8);

    // Mid-stream reset: three ops in flight are discarded
    send(32'h1234_5678, 1, 2'b00);
    send(32'h1234_5678, 2, 2'b01);
    send(32'h1234_5678, 3, 2'b10);
    do_reset(1);
    idle(8);
    send(32'h0000_0F00, 8, 2'b01);
    idle(8);

    // shamt = 0 for every op
    for (int o = 0; o < 4; o++) send(32'hDEAD_BEEF, 0, 2'(o));
    idle(8);

    // Randomized traffic with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send($urandom, $urandom_range(0, N - 1), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    begin
      int t = 0;
      while (exp_q.size() != 0 && t < 500) begin
        @(posedge clk);
        t++;
      end
      if (exp_q.size() != 0) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
      end
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined barrel shifter for the datapath ALU.
- Supports logical-left, logical-right and arithmetic-right shifts, plus optional rotate-right.
- Has one register stage per shift level (log2(N) levels), with a valid/ready handshake and full-pipeline stall on backpressure.
- Sits between operand decode and the ALU result mux; sustains one operation per cycle.

Parameters:
- N, 32, data width; power of two, N >= 4.
- L, $clog2(N), derived: shift-amount width and pipeline depth in cycles; not overridden.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/opcode presented this cycle.
- in_ready  output  1  shifter can accept; transfer when in_valid && in_ready.
- in  input  N  operand to shift.
- shamt  input  L  shift amount, 0..N-1, unsigned.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see Optional Feature).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
- out  output  N  shifted result.

Behaviour:
- Reset: rst sampled high at a clock edge clears every stage valid bit, data and carried shamt/op to 0. After reset, out = 0 and out_valid = 0. in_ready = 1 in the first cycle after reset. Reset mid-operation discards all in-flight ops, with no output for them.
- Stage k (k = 0..L-1):
  - Registers the data, the remaining shamt bits and op.
  - If shamt[k] = 1, shifts its input by 2^k; otherwise passes the input through.
  - Stage 0 takes in; stage L-1 drives out/out_valid directly from its registers. No combinational path from in to out.
- Fill rules per level:
  - SLL: zeros fill the low bits.
  - SRL: zeros fill the high bits.
  - SRA: copies of the original in[N-1] fill the high bits. The sign bit is carried down the pipe.
  - ROR: bits shifted out at the low end re-enter at the high end.
- Latency: exactly L cycles from accept to out_valid with no stall (N=32: 5 cycles). Throughput is 1 op/cycle.
- Stall:
  - stall = out_valid && !out_ready.
  - While stall, every stage holds data and valid, and in_ready = 0.
  - Otherwise in_ready = 1 and all stages advance. Bubbles advance with their valid = 0.
  - There is no bubble collapsing; stall is global.
- Output stability: out and out_valid stay stable while stalled.
- in_valid = 0 while in_ready = 1 inserts a bubble (valid 0), with no other effect.
- Boundaries:
  - shamt = 0 gives out = in for all ops.
  - shamt = N-1 is the maximum. SLL/SRL leave a single bit; SRA leaves sign replication.
  - Ops are independent per slot. Back-to-back ops with different op/shamt never interact.
- The shamt and op signals are don't-care when in_valid = 0.

Optional Feature:
- Macro: SHIFTER_ROTATE_EN.
- Defined:
  - op 11 performs rotate-right by shamt.
  - Each stage carries the rotate mux.
- Undefined:
  - Rotate logic is not generated.
  - op 11 behaves exactly as SRL (op 01).
  - All other behaviour and latency are unchanged.

Test Plan:
1. Reset, then SLL in=0x0000_0001 shamt=31 with out_ready=1 -> out=0x8000_0000, out_valid high exactly 5 cycles after accept. out=0 and out_valid=0 during the reset cycles.
2. SRA in=0x8000_00F0 shamt=4, then SRL same operands on the next cycle -> results 0xF800_000F then 0x0800_000F on consecutive cycles.
3. Streaming with backpressure:
   - Stimulus: 8 back-to-back SLL ops (in=0xA5A5_A5A5, shamt=0..7); hold out_ready=0 for 3 cycles once out_valid rises.
   - Required: in_ready=0 during the hold; out is stable at 0xA5A5_A5A5; all 8 results arrive in order with no loss or duplication.
4. ROR in=0x0000_00FF shamt=4 -> 0xF000_000F with SHIFTER_ROTATE_EN defined; 0x0000_000F without.
5. Reset mid-stream: assert rst for 1 cycle while 3 ops are in flight -> none of them emerges; out_valid=0 until a new op completes 5 cycles after its accept.
6. shamt=0 for each op with in=0xDEAD_BEEF -> out=0xDEAD_BEEF.
